dadda_mac: RTL and testbench

//  Sequential multiply-accumulate stage directly downstream of the 8x8 Dadda multiplier.
//  - Accepts unsigned 8-bit operand pairs over a valid/ready stream.
//  - Registers the operands and feeds them to an internal dadda instance (A, B -> 16-bit P).
//  - Registers the 16-bit product and sums a burst of products, up to and including the beat with in_last.
//  - Presents the burst sum, beat count and overflow flag on a valid/ready output.

---
 rtl/dadda_mac.sv | 188 ++++++++++++++++++
 tb/tb_dadda_mac.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dadda_mac.sv
// Multiply-accumulate stage: an 8x8 Dadda multiplier feeding a burst accumulator.
// Sums the products of each in_last-terminated burst and outputs the result over a valid/ready handshake.
module dadda (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  always_comb begin : reduce
    logic col [16][16];
    logic nc  [16][16];
    int   h   [16];
    int   nh  [16];
    int   d, idx, tot;
    logic [15:0] row0, row1;
    for (int c = 0; c < 16; c++) begin
      h[c] = 0;
      for (int r = 0; r < 16; r++) col[c][r] = 1'b0;
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        col[i+j][h[i+j]] = a[i] & b[j];
        h[i+j] = h[i+j] + 1;
      end
    // Dadda height targets 6, 4, 3, 2; carries into column c are counted before c is reduced
    for (int s = 0; s < 4; s++) begin
      d = (s == 0) ? 6 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
      for (int c = 0; c < 16; c++) begin
        nh[c] = 0;
        for (int r = 0; r < 16; r++) nc[c][r] = 1'b0;
      end
      for (int c = 0; c < 16; c++) begin
        idx = 0;
        for (int k = 0; k < 8; k++) begin
          tot = h[c] - idx + nh[c];
          if (tot > d) begin
            if (tot - d >= 2) begin
              nc[c][nh[c]] = col[c][idx] ^ col[c][idx+1] ^ col[c][idx+2];
              if (c < 15) begin
                nc[c+1][nh[c+1]] = (col[c][idx] & col[c][idx+1]) |
                                   (col[c][idx] & col[c][idx+2]) |
                                   (col[c][idx+1] & col[c][idx+2]);
                nh[c+1] = nh[c+1] + 1;
              end
              idx = idx + 3;
            end else begin
              nc[c][nh[c]] = col[c][idx] ^ col[c][idx+1];
              if (c < 15) begin
                nc[c+1][nh[c+1]] = col[c][idx] & col[c][idx+1];
                nh[c+1] = nh[c+1] + 1;
              end
              idx = idx + 2;
            end
            nh[c] = nh[c] + 1;
          end
        end
        for (int r = 0; r < 16; r++)
          if (r >= idx && r < h[c]) begin
            nc[c][nh[c]] = col[c][r];
            nh[c] = nh[c] + 1;
          end
      end
      for (int c = 0; c < 16; c++) begin
        h[c] = nh[c];
        for (int r = 0; r < 16; r++) col[c][r] = nc[c][r];
      end
    end
    for (int c = 0; c < 16; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
    p = row0 + row1;
  end
endmodule

module dadda_mac #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_a,
  input  logic [LEN-1:0]   in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN-1:0]     a_q, a_d, b_q, b_d;
  logic               last1_q, last1_d, s1_vld_q, s1_vld_d;
  logic [2*LEN-1:0]   prod_q, prod_d, prod_w;
  logic               last2_q, last2_d, s2_vld_q, s2_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [ACC_W:0]     sum_w;

  dadda u_dadda (.a(a_q), .b(b_q), .p(prod_w));

  assign in_ready = (state_q == ACC);
  assign sum_w    = {1'b0, acc_q} + {{(ACC_W+1-2*LEN){1'b0}}, prod_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    last1_d     = last1_q;
    s1_vld_d    = in_valid && in_ready;
    prod_d      = prod_q;
    last2_d     = last2_q;
    s2_vld_d    = s1_vld_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (in_valid && in_ready) begin
      a_d     = in_a;
      b_d     = in_b;
      last1_d = in_last;
    end
    if (s1_vld_q) begin
      prod_d  = prod_w;
      last2_d = last1_q;
    end
    if (s2_vld_q) begin
      acc_d = sum_w[ACC_W-1:0];
      ovf_d = ovf_q | sum_w[ACC_W];
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      ACC:   if (in_valid && in_last) state_d = DRAIN;
      DRAIN: if (s2_vld_q && last2_q) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
             end
      DONE:  if (out_ready) begin
               state_d     = ACC;
               out_valid_d = 1'b0;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
             end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      a_q         <= '0;
      b_q         <= '0;
      last1_q     <= 1'b0;
      s1_vld_q    <= 1'b0;
      prod_q      <= '0;
      last2_q     <= 1'b0;
      s2_vld_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last1_q     <= last1_d;
      s1_vld_q    <= s1_vld_d;
      prod_q      <= prod_d;
      last2_q     <= last2_d;
      s2_vld_q    <= s2_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_dadda_mac.sv
// Bench for dadda_mac: a 24-bit and a 16-bit accumulator instance share one stimulus stream
// and are checked against an arithmetic burst-sum model.
module tb_dadda_mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_count;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_acc16;
  logic [7:0]  out_count16;

  int n_chk = 0, n_pass = 0;
  longint exp_sum = 0;
  int     exp_n = 0;

  always #5 clk = ~clk;

  dadda_mac #(.LEN(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf));

  dadda_mac #(.LEN(8), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_acc(out_acc16), .out_count(out_count16), .out_ovf(out_ovf16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    longint cnt_sat;
    cnt_sat = (exp_n > 255) ? 255 : exp_n;
    chk({tag, " acc24"}, {8'd0, out_acc},   32'(exp_sum % (64'd1 << 24)));
    chk({tag, " ovf24"}, {31'd0, out_ovf},  32'(exp_sum >= (64'd1 << 24)));
    chk({tag, " cnt24"}, {24'd0, out_count}, 32'(cnt_sat));
    chk({tag, " acc16"}, {16'd0, out_acc16}, 32'(exp_sum % (64'd1 << 16)));
    chk({tag, " ovf16"}, {31'd0, out_ovf16}, 32'(exp_sum >= (64'd1 << 16)));
    chk({tag, " cnt16"}, {24'd0, out_count16}, 32'(cnt_sat));
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(posedge clk);
    if (!in_ready) chk("ready at beat", {31'd0, in_ready}, 32'd1);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    exp_sum += longint'(a) * longint'(b);
    exp_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait for the result, hold it under backpressure for `hold` cycles, then drain it.
  task automatic finish_burst(input string tag, input int hold);
    int k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk({tag, " latency"}, 32'(k), 32'd2);
    chk({tag, " valid16"}, {31'd0, out_valid16}, 32'd1);
    check_outputs(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold ready"}, {31'd0, in_ready}, 32'd0);
      check_outputs({tag, " hold"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drained valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " ready after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " cleared acc"}, {8'd0, out_acc}, 32'd0);
    exp_sum = 0;
    exp_n = 0;
  endtask

  initial begin
    int len;
    logic saw_valid;
    // T1 reset
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    idle(1);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_outputs("rst");

    // T2 single maximal beat
    beat(8'd255, 8'd255, 1'b1);
    finish_burst("T2", 0);

    // T3 burst with a bubble
    beat(8'd3, 8'd5, 1'b0);
    beat(8'd7, 8'd9, 1'b0);
    idle(1);
    beat(8'd0, 8'd200, 1'b0);
    beat(8'd16, 8'd16, 1'b1);
    chk("T3 model sum", 32'(exp_sum), 32'd334);
    finish_burst("T3", 0);

    // T4 two maximal beats: the 16-bit instance overflows to 64514
    beat(8'd255, 8'd255, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    finish_burst("T4", 0);

    // T5 backpressure, then a fresh burst
    beat(8'd255, 8'd255, 1'b1);
    finish_burst("T5", 5);
    beat(8'd2, 8'd3, 1'b1);
    finish_burst("T5 next", 0);

    // all-zero burst
    for (int i = 0; i < 4; i++) beat(8'd0, 8'($urandom_range(0, 255)), i == 3);
    finish_burst("zeros", 1);

    // T6 reset mid-burst
    beat(8'd10, 8'd10, 1'b0);
    beat(8'd20, 8'd20, 1'b0);
    rst_n = 1'b0; #3; rst_n = 1'b1;
    exp_sum = 0; exp_n = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      saw_valid |= out_valid;
    end
    chk("T6 no stale valid", {31'd0, saw_valid}, 32'd0);
    beat(8'd2, 8'd3, 1'b1);
    finish_burst("T6", 0);

    // long maximal burst: 24-bit overflow and count saturation
    for (int i = 0; i < 300; i++) beat(8'd255, 8'd255, i == 299);
    finish_burst("sat", 2);

    // randomized bursts with bubbles and backpressure
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        beat(8'($urandom), 8'($urandom), i == len - 1);
      end
      finish_burst("rand", $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
